// File: rtl/umi_regbank_if.sv
// Register-strobe bus between the UMI register interface (master) and umi_regbank (slave).
interface umi_regbank_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic [AW-1:0]   reg_addr;
  logic            reg_write;
  logic            reg_read;
  logic [7:0]      reg_cmd;
  logic [3:0]      reg_size;
  logic [4*DW-1:0] reg_wrdata;
  logic [DW-1:0]   reg_rddata;

  modport master (
    output reg_addr, reg_write, reg_read, reg_cmd, reg_size, reg_wrdata,
    input  reg_rddata
  );

  modport slave (
    input  reg_addr, reg_write, reg_read, reg_cmd, reg_size, reg_wrdata,
    output reg_rddata
  );
endinterface

// File: rtl/umi_regbank.sv
// UMI register bank: ID, free-running timer, sticky W1C status, irq mask, CFG registers.
// Optional write-protect lock register enabled by defining UMI_REGBANK_LOCK_EN.
module umi_regbank #(
  parameter int            AW    = 64,
  parameter int            DW    = 64,
  parameter int            NREG  = 16,
  parameter logic [DW-1:0] REGID = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  umi_regbank_if.slave           bus,
  input  logic [DW-1:0]          ev_in,
  output logic                   irq,
  output logic [(NREG-5)*DW-1:0] cfg_out,
  output logic                   locked
);

  localparam int NB   = DW / 8;
  localparam int SH   = $clog2(NB);
  localparam int IW   = $clog2(NREG);
  localparam int NCFG = NREG - 5;

  logic [IW-1:0]              idx;
  logic [NB-1:0]              byte_mask;
  logic [DW-1:0]              bit_mask;
  logic [DW-1:0]              wr_shift;
  logic                       wr_ok;
  logic                       lock_q;
  logic [NCFG-1:0]            wr_cfg;
  logic [DW-1:0]              rd_word;
  logic [DW-1:0]              status_next;
  logic [DW-1:0]              mask_next;
  logic [DW-1:0]              timer_q;
  logic [DW-1:0]              status_q;
  logic [DW-1:0]              mask_q;
  logic [NCFG-1:0][DW-1:0]    cfg_q;
  logic [DW-1:0]              rd_q;
  logic                       irq_q;
  int                         off;
  int                         nbytes;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] m,
                                          input logic [DW-1:0] d);
    return (old & ~m) | (d & m);
  endfunction

  assign idx = bus.reg_addr[SH +: IW];

  // Byte lanes touched by the write: data byte i lands on register byte off+i.
  always_comb begin
    off = 0;
    for (int b = 0; b < SH; b++) begin
      if (bus.reg_addr[b]) off = off + (1 << b);
    end
    nbytes   = 1 << bus.reg_size;
    wr_shift = bus.reg_wrdata[DW-1:0] << (8 * off);
    bit_mask = '0;
    for (int b = 0; b < NB; b++) begin
      byte_mask[b]       = (b >= off) && (b < off + nbytes);
      bit_mask[b*8 +: 8] = {8{byte_mask[b]}};
    end
    wr_ok = bus.reg_write && (int'(bus.reg_size) <= SH) && (int'(idx) < NREG);
    for (int r = 0; r < NCFG; r++) begin
      wr_cfg[r] = wr_ok && !lock_q && (int'(idx) == r + 5);
    end
  end

  always_comb begin
    status_next = status_q | ev_in;
    if (wr_ok && idx == IW'(2)) status_next = (status_q & ~(wr_shift & bit_mask)) | ev_in;
    mask_next = mask_q;
    if (wr_ok && idx == IW'(3) && !lock_q) mask_next = merge(mask_q, bit_mask, wr_shift);
  end

  always_comb begin
    rd_word = '0;
    if (idx == IW'(0)) rd_word = REGID;
    if (idx == IW'(1)) rd_word = timer_q;
    if (idx == IW'(2)) rd_word = status_q;
    if (idx == IW'(3)) rd_word = mask_q;
    if (idx == IW'(4)) rd_word = {{(DW-1){1'b0}}, lock_q};
    for (int r = 0; r < NCFG; r++) begin
      if (int'(idx) == r + 5) rd_word = cfg_q[r];
    end
  end

  // Reads sample pre-write state, so a combined read+write returns the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q  <= '0;
      status_q <= '0;
      mask_q   <= '0;
      cfg_q    <= '0;
      rd_q     <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ok && idx == IW'(1) && !lock_q) timer_q <= merge(timer_q, bit_mask, wr_shift);
      else timer_q <= timer_q + DW'(1);
      status_q <= status_next;
      mask_q   <= mask_next;
      irq_q    <= |(status_next & mask_next);
      for (int r = 0; r < NCFG; r++) begin
        if (wr_cfg[r]) cfg_q[r] <= merge(cfg_q[r], bit_mask, wr_shift);
      end
      if (bus.reg_read) rd_q <= rd_word;
    end
  end

`ifdef UMI_REGBANK_LOCK_EN
  // Lock is one-way: only reset can clear it.
  always_ff @(posedge clk) begin
    if (reset) lock_q <= 1'b0;
    else if (wr_ok && idx == IW'(4) && bit_mask[0] && wr_shift[0]) lock_q <= 1'b1;
  end
`else
  assign lock_q = 1'b0;
`endif

  assign bus.reg_rddata = rd_q;
  assign irq            = irq_q;
  assign cfg_out        = cfg_q;
  assign locked         = lock_q;

  logic unused_bits;
  assign unused_bits = ^{bus.reg_cmd, bus.reg_wrdata[4*DW-1:DW], bus.reg_addr[AW-1:SH+IW]};

endmodule

// File: tb/tb_umi_regbank.sv
// Self-checking bench for umi_regbank: directed steps plus randomized traffic against a byte-level model.
module tb_umi_regbank;
  localparam int            AW    = 64;
  localparam int            DW    = 64;
  localparam int            NREG  = 12;
  localparam logic [63:0]   REGID = 64'h1234;
  localparam int            CW    = (NREG - 5) * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic [63:0]   ev_in;
  logic          irq;
  logic          locked;
  logic [CW-1:0] cfg_out;

  umi_regbank_if #(.AW(AW), .DW(DW)) bus ();

  umi_regbank #(.AW(AW), .DW(DW), .NREG(NREG), .REGID(REGID)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .ev_in   (ev_in),
    .irq     (irq),
    .cfg_out (cfg_out),
    .locked  (locked)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] m_timer, m_status, m_mask;
  logic [63:0] m_cfg [NREG];
  logic        m_lock;
  logic [63:0] exp_rd;
  logic        exp_irq;
  logic [63:0] ev_cur;

  // Byte placement as the bus describes it: data byte i -> register byte (addr%8)+i.
  function automatic logic [63:0] place(input logic [63:0] old, input logic [63:0] addr,
                                        input logic [3:0] size, input logic [255:0] data);
    logic [63:0] r;
    int o, n;
    r = old;
    o = int'(addr[2:0]);
    n = 1 << size;
    for (int i = 0; i < n; i++) begin
      if (o + i < 8) r[(o+i)*8 +: 8] = data[i*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [63:0] modelRead(input int i);
    case (i)
      0: return REGID;
      1: return m_timer;
      2: return m_status;
      3: return m_mask;
      4: return {63'b0, m_lock};
      default: return (i < NREG) ? m_cfg[i] : 64'h0;
    endcase
  endfunction

  task automatic modelStep(input logic rst, input logic wr, input logic rd, input logic [63:0] addr,
                           input logic [3:0] size, input logic [255:0] data, input logic [63:0] ev);
    int i;
    logic [63:0] nt, ns, nm, clr;
    if (rst) begin
      m_timer = 0; m_status = 0; m_mask = 0; m_lock = 0; exp_rd = 0; exp_irq = 0;
      for (int k = 0; k < NREG; k++) m_cfg[k] = 0;
      return;
    end
    i = int'(addr[6:3]);
    if (rd) exp_rd = modelRead(i);
    nt = m_timer + 64'd1;
    ns = m_status | ev;
    nm = m_mask;
    if (wr && size <= 4'd3 && i < NREG) begin
      case (i)
        1: if (!m_lock) nt = place(m_timer, addr, size, data);
        2: begin clr = place(64'h0, addr, size, data); ns = (m_status & ~clr) | ev; end
        3: if (!m_lock) nm = place(m_mask, addr, size, data);
        4: begin
`ifdef UMI_REGBANK_LOCK_EN
          clr = place(64'h0, addr, size, data);
          if (clr[0]) m_lock = 1'b1;
`endif
        end
        default: if (i >= 5 && !m_lock) m_cfg[i] = place(m_cfg[i], addr, size, data);
      endcase
    end
    m_timer = nt; m_status = ns; m_mask = nm;
    exp_irq = |(ns & nm);
  endtask

  task automatic checkValue(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    logic [CW-1:0] ec;
    for (int r = 0; r < NREG - 5; r++) ec[r*64 +: 64] = m_cfg[r+5];
    checkValue("rddata", CW'(bus.reg_rddata), CW'(exp_rd));
    checkValue("irq", CW'(irq), CW'(exp_irq));
    checkValue("locked", CW'(locked), CW'(m_lock));
    checkValue("cfg_out", cfg_out, ec);
  endtask

  // One clock: drive at the falling edge, advance the model, check at the next falling edge.
  task automatic applyStimulus(input logic rst, input logic wr, input logic rd, input logic [63:0] addr,
                               input logic [3:0] size, input logic [255:0] data, input logic [63:0] ev);
    reset          = rst;
    bus.reg_write  = wr;
    bus.reg_read   = rd;
    bus.reg_addr   = addr;
    bus.reg_size   = size;
    bus.reg_wrdata = data;
    bus.reg_cmd    = 8'($urandom);
    ev_in          = ev;
    modelStep(rst, wr, rd, addr, size, data, ev);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic doWrite(input int i, input int o, input logic [3:0] size, input logic [255:0] data);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'(i * 8 + o), size, data, ev_cur);
  endtask

  task automatic doRead(input int i);
    applyStimulus(1'b0, 1'b0, 1'b1, 64'(i * 8), 4'd3, 256'h0, ev_cur);
  endtask

  task automatic doIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 4'd0, 256'h0, ev_cur);
  endtask

  initial begin
    logic [63:0] ra;
    reset = 1'b1; ev_in = '0; ev_cur = '0;
    bus.reg_write = 0; bus.reg_read = 0; bus.reg_addr = '0;
    bus.reg_size = '0; bus.reg_wrdata = '0; bus.reg_cmd = '0;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 4'd0, 256'h0, 64'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 64'h28, 4'd3, 256'hFF, 64'h0);

    doRead(0);
    checkValue("id_read", CW'(bus.reg_rddata), CW'(64'h1234));
    doIdle(); doIdle();
    checkValue("id_hold", CW'(bus.reg_rddata), CW'(64'h1234));

    doWrite(5, 3, 4'd0, 256'hAB);
    checkValue("cfg_byte3", CW'(cfg_out[31:24]), CW'(8'hAB));
    doWrite(5, 0, 4'd4, {4{64'hFFFF_FFFF_FFFF_FFFF}});
    doRead(5);
    checkValue("cfg_size4_ignored", CW'(bus.reg_rddata), CW'(64'hAB00_0000));

    doWrite(1, 0, 4'd3, 256'hFFFF_FFFF_FFFF_FFFE);
    doIdle(); doIdle(); doIdle();
    doRead(1);
    checkValue("timer_wrap", CW'(bus.reg_rddata), CW'(64'h1));

    doWrite(3, 0, 4'd3, 256'h4);
    ev_cur = 64'h4; doIdle();
    ev_cur = 64'h0;
    checkValue("irq_set", CW'(irq), CW'(1'b1));
    ev_cur = 64'h4; doWrite(2, 0, 4'd3, 256'h4);
    ev_cur = 64'h0; doRead(2);
    checkValue("status_set_wins", CW'(bus.reg_rddata), CW'(64'h4));
    doWrite(2, 0, 4'd3, 256'h4);
    checkValue("irq_clear", CW'(irq), CW'(1'b0));
    doRead(2);

    doWrite(4, 0, 4'd0, 256'h1);
    doWrite(5, 0, 4'd3, 256'hFF);
    doRead(5); doRead(4);
`ifndef UMI_REGBANK_LOCK_EN
    checkValue("lock_reads_zero", CW'(bus.reg_rddata), CW'(64'h0));
`endif

    doWrite(NREG, 0, 4'd3, 256'hDEAD_BEEF);
    doRead(NREG);
    checkValue("oor_read", CW'(bus.reg_rddata), CW'(64'h0));

    doWrite(3, 0, 4'd3, 256'hFFFF);
    ev_cur = 64'h1; doRead(0);
    applyStimulus(1'b1, 1'b1, 1'b1, 64'h30, 4'd3, 256'h55, 64'h1);
    ev_cur = 64'h0;
    checkValue("reset_cfg", cfg_out, '0);
    checkValue("reset_rd", CW'(bus.reg_rddata), CW'(64'h0));

    for (int n = 0; n < 800; n++) begin
      ra = {$urandom, $urandom};
      ra[6:3] = 4'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom), ra,
                    4'($urandom_range(0, 4)),
                    {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                    ($urandom_range(0, 3) == 0) ? (64'h1 << $urandom_range(0, 63)) : 64'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
